// File: rtl/rcc_byte_framer.sv
// rcc_byte_framer: wraps a fixed-length payload from the byte serializer into
// a frame: header, 16-bit length (MSB first), payload, check byte. The output
// is a valid/ready byte stream; a small buffer absorbs input during stalls.
// Optional macro FRAMER_CRC8_EN: the check byte becomes CRC-8 (poly 0x07)
// instead of the mod-256 additive sum.
module rcc_byte_framer #(
    parameter int         BUF_DEPTH   = 16,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic        SLOW_CLK,
    input  logic        SLOW_RESET,
    input  logic        i_start,
    input  logic [15:0] i_frame_len,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, LEN_HI, LEN_LO, PAYLOAD, CHK} state_t;

    state_t      state, state_nxt;
    logic [7:0]  buf_mem [BUF_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, buf_cnt;
    logic [15:0] len_r, in_cnt, out_cnt;
    logic [7:0]  acc;
    logic [7:0]  buf_rd;
    logic [7:0]  ld_data;
    logic        accept, buf_empty, buf_full, wr_en;
    logic        rd_en, abort, start, ld, drop_valid, acc_upd, done_set;

    // One emitted byte folded into the running check value.
    function automatic logic [7:0] chk_step(input logic [7:0] a, input logic [7:0] b);
`ifdef FRAMER_CRC8_EN
        logic [7:0] c;
        c = a ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
`else
        return a + b;
`endif
    endfunction

    // The pointer MSB separates full from empty; the difference is occupancy.
    assign buf_cnt   = wr_ptr - rd_ptr;
    assign buf_empty = (buf_cnt == '0);
    assign buf_full  = (buf_cnt == (AW+1)'(BUF_DEPTH));
    assign buf_rd    = buf_mem[rd_ptr[AW-1:0]];
    assign accept    = o_valid && i_ready;
    // Input is live for the whole frame; bytes beyond the latched length are dropped.
    assign wr_en     = (state != IDLE) && i_byte_valid && (in_cnt < len_r);

    // FSM state register.
    always_ff @(posedge SLOW_CLK) begin
        if (SLOW_RESET) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state plus output-register load decisions; the state names the byte held in o_data.
    always_comb begin
        state_nxt  = state;
        ld         = 1'b0;
        ld_data    = 8'h00;
        drop_valid = 1'b0;
        rd_en      = 1'b0;
        acc_upd    = 1'b0;
        start      = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                start     = 1'b1;
                ld        = 1'b1;
                ld_data   = HEADER_BYTE;
                state_nxt = HDR;
            end
            HDR: if (accept) begin
                ld        = 1'b1;
                ld_data   = len_r[15:8];
                acc_upd   = 1'b1;
                state_nxt = LEN_HI;
            end
            LEN_HI: if (accept) begin
                ld        = 1'b1;
                ld_data   = len_r[7:0];
                acc_upd   = 1'b1;
                state_nxt = LEN_LO;
            end
            LEN_LO: if (accept) begin
                if (len_r == 16'd0) begin
                    ld        = 1'b1;
                    ld_data   = acc;
                    state_nxt = CHK;
                end else begin
                    state_nxt = PAYLOAD;
                    if (!buf_empty) begin
                        rd_en   = 1'b1;
                        ld      = 1'b1;
                        ld_data = buf_rd;
                        acc_upd = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (accept && (out_cnt == len_r - 16'd1)) begin
                    ld        = 1'b1;
                    ld_data   = acc;
                    state_nxt = CHK;
                end else if (!buf_empty && (!o_valid || accept)) begin
                    rd_en   = 1'b1;
                    ld      = 1'b1;
                    ld_data = buf_rd;
                    acc_upd = 1'b1;
                end else if (accept) begin
                    drop_valid = 1'b1;
                end
            end
            CHK: if (accept) begin
                done_set   = 1'b1;
                drop_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A write into a full buffer with no read this cycle kills the frame;
        // o_valid is pulled even if the byte was never accepted.
        abort = wr_en && buf_full && !rd_en;
        if (abort) begin
            state_nxt  = IDLE;
            ld         = 1'b0;
            drop_valid = 1'b1;
            acc_upd    = 1'b0;
            done_set   = 1'b0;
        end
    end

    // Output register, status flags, pointers, counters and check accumulator.
    always_ff @(posedge SLOW_CLK) begin
        if (SLOW_RESET) begin
            o_data     <= 8'h00;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len_r      <= 16'd0;
            in_cnt     <= 16'd0;
            out_cnt    <= 16'd0;
            acc        <= 8'h00;
        end else begin
            o_done <= done_set;
            if (ld) begin
                o_valid <= 1'b1;
                o_data  <= ld_data;
            end else if (drop_valid) begin
                o_valid <= 1'b0;
            end
            if (acc_upd) acc <= chk_step(acc, ld_data);
            if (start) begin
                len_r      <= i_frame_len;
                acc        <= 8'h00;
                in_cnt     <= 16'd0;
                out_cnt    <= 16'd0;
                o_overflow <= 1'b0;
                o_busy     <= 1'b1;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else if (abort) begin
                o_overflow <= 1'b1;
                o_busy     <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (done_set) o_busy <= 1'b0;
                if (wr_en) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                    in_cnt <= in_cnt + 16'd1;
                end
                if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
                if ((state == PAYLOAD) && accept) out_cnt <= out_cnt + 16'd1;
            end
        end
    end

    // Payload storage; data only, never reset.
    always_ff @(posedge SLOW_CLK) begin
        if (wr_en && !abort) buf_mem[wr_ptr[AW-1:0]] <= i_byte;
    end

endmodule

// File: tb/tb_rcc_byte_framer.sv
// Self-checking bench for rcc_byte_framer: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_rcc_byte_framer;

    localparam int         BUF_DEPTH   = 16;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [15:0] i_frame_len;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_byte;

    rcc_byte_framer #(.BUF_DEPTH(BUF_DEPTH), .HEADER_BYTE(HEADER_BYTE)) dut (
        .SLOW_CLK     (clk),
        .SLOW_RESET   (rst),
        .i_start      (i_start),
        .i_frame_len  (i_frame_len),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Check byte from the frame definition: message = len_hi, len_lo, payload.
    function automatic logic [7:0] model_check(input int len);
        logic [7:0] msg[$];
        msg.push_back(8'((len >> 8) & 255));
        msg.push_back(8'(len & 255));
        foreach (pay_q[i]) msg.push_back(pay_q[i]);
`ifdef FRAMER_CRC8_EN
        begin
            // Long division of the message bit stream by x^8+x^2+x+1.
            int rem = 0;
            foreach (msg[i]) begin
                for (int b = 7; b >= 0; b--) begin
                    rem = (rem << 1) | ((msg[i] >> b) & 1);
                    if (rem >= 256) rem = rem ^ 'h107;
                end
            end
            for (int b = 0; b < 8; b++) begin
                rem = rem << 1;
                if (rem >= 256) rem = rem ^ 'h107;
            end
            return 8'(rem);
        end
`else
        begin
            int s = 0;
            foreach (msg[i]) s += msg[i];
            return 8'(s % 256);
        end
`endif
    endfunction

    // Drive one frame from pay_q; rmode 0 = always ready, 1 = toggling, 2 = random.
    task automatic run_frame(input int len, input int rmode, input int gap_pct);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [7:0] held = 8'h00;
        exp_q = {};
        exp_q.push_back(HEADER_BYTE);
        exp_q.push_back(8'((len >> 8) & 255));
        exp_q.push_back(8'(len & 255));
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
        exp_q.push_back(model_check(len));

        i_byte_valid = 1'b0;
        i_frame_len  = 16'(len);
        i_start      = 1'b1;
        step();
        i_start = 1'b0;
        check("start_valid", o_valid, 1);
        check("start_busy", o_busy, 1);
        check("start_ovf_clr", o_overflow, 0);

        while (got < exp_q.size() && cyc < 3000) begin
            if (sent < len && $urandom_range(0, 99) >= gap_pct) begin
                i_byte_valid = 1'b1;
                i_byte       = pay_q[sent];
                sent++;
            end else begin
                i_byte_valid = 1'b0;
                i_byte       = 8'($urandom);
            end
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 2 == 0);
                default: i_ready = ($urandom_range(0, 99) < 70);
            endcase
            if (stalled) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, held);
            end
            if (o_valid && i_ready) begin
                check("frame_byte", o_data, exp_q[got]);
                last_byte = o_data;
                got++;
                stalled = 1'b0;
            end else if (o_valid) begin
                stalled = 1'b1;
                held    = o_data;
            end else begin
                stalled = 1'b0;
            end
            step();
            cyc++;
        end
        i_byte_valid = 1'b0;
        check("frame_complete", got, exp_q.size());
        check("done_pulse", o_done, 1);
        check("done_busy_low", o_busy, 0);
        check("done_valid_low", o_valid, 0);
        check("no_overflow", o_overflow, 0);
        step();
        check("done_one_cycle", o_done, 0);
    endtask

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_frame_len  = 16'd0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_ready      = 1'b0;
        last_byte    = 8'h00;
        step();
        step();
        check("rst_data", o_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_ovf", o_overflow, 0);
        rst = 1'b0;
        step();

        // Basic frame: A5 00 04 01 02 03 04 0E (sum build).
        pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(4, 0, 0);

        // Zero-length frame, then a stray byte while idle.
        pay_q = {};
        run_frame(0, 0, 0);
        i_ready      = 1'b1;
        i_byte       = 8'h55;
        i_byte_valid = 1'b1;
        step();
        i_byte_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("idle_no_output", o_valid, 0);
            step();
        end
        check("idle_busy", o_busy, 0);

        // Backpressure: ready toggling every cycle.
        pay_q = {};
        for (int k = 0; k < 8; k++) pay_q.push_back(8'($urandom));
        run_frame(8, 1, 0);

        // Overflow: 17 bytes into a 16-byte buffer with the output stalled.
        i_ready     = 1'b0;
        i_frame_len = 16'd32;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            i_byte_valid = 1'b1;
            i_byte       = 8'(k);
            step();
            if (k == 15) begin
                check("ovf_not_yet", o_overflow, 0);
                check("ovf_hdr_held", o_data, HEADER_BYTE);
            end
        end
        i_byte_valid = 1'b0;
        check("ovf_set", o_overflow, 1);
        check("ovf_valid_drop", o_valid, 0);
        check("ovf_busy_low", o_busy, 0);
        check("ovf_no_done", o_done, 0);
        i_ready = 1'b1;
        step();
        check("ovf_sticky", o_overflow, 1);
        check("ovf_still_no_done", o_done, 0);
        check("ovf_idle_valid", o_valid, 0);

        // Recovery frame, len=1 payload 01; check byte differs per build.
        pay_q = {8'h01};
        run_frame(1, 0, 0);
`ifdef FRAMER_CRC8_EN
        check("chk_len1", last_byte, 8'h12);
`else
        check("chk_len1", last_byte, 8'h02);
`endif

        // Reset in the middle of a payload.
        i_ready     = 1'b1;
        i_frame_len = 16'd8;
        i_start     = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_byte_valid = 1'b1;
            i_byte       = 8'(k + 16);
            step();
        end
        i_byte_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_data", o_data, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_ovf", o_overflow, 0);
        rst = 1'b0;
        step();
        pay_q = {8'hFF, 8'h80, 8'h7F};
        run_frame(3, 0, 0);

        // Randomized frames within buffer depth, random gaps and backpressure.
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(0, BUF_DEPTH);
            pay_q = {};
            for (int k = 0; k < len; k++) pay_q.push_back(8'($urandom));
            run_frame(len, 2, 30);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
